// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and word constants for the fetch stage
package fetch_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        ERROR = 2'd3
    } state_t;
endpackage

// File: rtl/pc_unit.sv
// pc_unit: load-enabled program counter with sequential/redirect next-PC mux
module pc_unit
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              load,
    input  logic              branch_en,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4
);
    logic [WORD_W-1:0] pc_next;

    assign pc_plus4 = pc + PC_STEP;
    // Masking both legs keeps the target word-aligned; pc_plus4 is already aligned.
    assign pc_next = (branch_en ? branch_target : pc_plus4) & ~32'h3;

    always_ff @(posedge CLK)
        if (reset)
            pc <= PC_RESET;
        else if (load)
            pc <= pc_next;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, imem request/ready handshake, instruction capture and timeout
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_RESET = 32'h0000_0000,
    parameter int                WAIT_MAX = 15
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [WORD_W-1:0] branch_target,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic              instr_load,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              fetch_err
);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state, state_n;
    logic [7:0] wait_cnt;
    logic       pc_load, capture, timeout;

    pc_unit #(.PC_RESET(PC_RESET)) u_pc (
        .CLK          (CLK),
        .reset        (reset),
        .load         (pc_load),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
    );

    assign imem_addr = pc;

    always_ff @(posedge CLK)
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            instr     <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= capture ? '0 : (state == FETCH && !timeout) ? wait_cnt + 8'd1 : wait_cnt;
            instr     <= capture ? imem_rdata : instr;
            fetch_err <= fetch_err | timeout;
        end

    always_comb begin
        state_n    = state;
        imem_req   = 1'b0;
        instr_load = 1'b0;
        pc_load    = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            IDLE:  state_n = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                capture  = imem_ready;
                timeout  = !imem_ready && wait_cnt == WAIT_LAST;
                state_n  = imem_ready ? ISSUE : timeout ? ERROR : FETCH;
            end
            ISSUE: begin
                instr_load = !stall;
                pc_load    = !stall;
                state_n    = stall ? ISSUE : FETCH;
            end
            ERROR: state_n = ERROR;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch handshake, stall, redirect, timeout and reset
module tb_instr_fetch;
    logic        CLK = 1'b0;
    logic        reset, stall, branch_en, imem_ready;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, instr_load, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    int          checks = 0;
    int          passes = 0;

    always #5 CLK = ~CLK;

    instr_fetch #(.PC_RESET(32'h0), .WAIT_MAX(15)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .stall        (stall),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_load   (instr_load),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_err    (fetch_err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; stall = 0; branch_en = 0; branch_target = 0; imem_ready = 0; imem_rdata = 0;
        tick(); tick();
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_instr", instr, 0);
        check("rst_err", 32'(fetch_err), 0);
        check("rst_load", 32'(instr_load), 0);
        reset = 0; imem_ready = 1; imem_rdata = 32'h2008_0005;
        tick();
        check("f0_req", 32'(imem_req), 1);
        check("f0_addr", imem_addr, 32'h0);
        check("f0_load", 32'(instr_load), 0);
        tick();
        check("i0_load", 32'(instr_load), 1);
        check("i0_instr", instr, 32'h2008_0005);
        check("i0_req", 32'(imem_req), 0);
        imem_rdata = 32'h1111_2222;
        tick();
        check("f1_addr", imem_addr, 32'h4);
        check("f1_instr_hold", instr, 32'h2008_0005);
        tick();
        check("i1_instr", instr, 32'h1111_2222);
        tick();
        imem_ready = 0; imem_rdata = 32'h3333_4444;
        for (int i = 0; i < 3; i++) begin
            check("wait_req", 32'(imem_req), 1);
            check("wait_addr", imem_addr, 32'h8);
            check("wait_load", 32'(instr_load), 0);
            tick();
        end
        imem_ready = 1;
        check("wait4_req", 32'(imem_req), 1);
        check("wait4_addr", imem_addr, 32'h8);
        tick();
        check("i2_load", 32'(instr_load), 1);
        check("i2_instr", instr, 32'h3333_4444);
        check("i2_err", 32'(fetch_err), 0);
        tick();
        check("f3_addr", imem_addr, 32'hC);
        imem_rdata = 32'h5555_6666;
        tick();
        stall = 1; branch_en = 1; branch_target = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            #0;
            check("stall_load", 32'(instr_load), 0);
            check("stall_pc", pc, 32'hC);
            tick();
        end
        stall = 0; branch_en = 0;
        #1;
        check("unstall_load", 32'(instr_load), 1);
        check("unstall_instr", instr, 32'h5555_6666);
        tick();
        check("f4_addr", imem_addr, 32'h10);
        tick();
        branch_en = 1; branch_target = 32'h0000_0103;
        #1;
        check("br_load", 32'(instr_load), 1);
        tick();
        branch_en = 0;
        check("br_addr", imem_addr, 32'h100);
        check("br_pc4", pc_plus4, 32'h104);
        tick();
        branch_en = 1; branch_target = 32'hFFFF_FFFF;
        tick();
        branch_en = 0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4, 32'h0);
        tick(); tick();
        check("wrap_next", imem_addr, 32'h0);
        imem_ready = 0;
        for (int i = 0; i < 15; i++) begin
            check("to_req", 32'(imem_req), 1);
            check("to_err", 32'(fetch_err), 0);
            tick();
        end
        check("to_err_set", 32'(fetch_err), 1);
        check("to_req_drop", 32'(imem_req), 0);
        imem_ready = 1; stall = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("err_hold", 32'(fetch_err), 1);
            check("err_req", 32'(imem_req), 0);
            check("err_load", 32'(instr_load), 0);
        end
        reset = 1;
        tick();
        check("err_clr", 32'(fetch_err), 0);
        check("err_clr_addr", imem_addr, 32'h0);
        reset = 0; imem_ready = 1; imem_rdata = 32'hAAAA_0001;
        tick(); tick();
        branch_en = 1; branch_target = 32'h0000_0020;
        tick();
        branch_en = 0; imem_ready = 0;
        check("r_addr20", imem_addr, 32'h20);
        tick();
        reset = 1;
        check("r_wait2_req", 32'(imem_req), 1);
        tick();
        reset = 0; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
        check("r_req", 32'(imem_req), 0);
        check("r_pc", pc, 32'h0);
        check("r_load", 32'(instr_load), 0);
        check("r_instr", instr, 32'h0);
        tick();
        check("r_instr2", instr, 32'h0);
        check("r_refetch", 32'(imem_req), 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the multi-cycle datapath. Holds the program counter, fetches one 32-bit word per instruction from instruction memory over a request/ready handshake, and presents it on `instr`. It pulses `instr_load` to drive the load enable of the downstream 32-bit instruction register. Applies branch redirects, honours a downstream stall, and flags memory that never answers.

## Interface
- `PC_RESET`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `WAIT_MAX`, 15: maximum number of FETCH cycles without `imem_ready` before error; range 1..255.
- `CLK` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `CLK`.
- `stall` in 1: downstream not ready; holds the stage in ISSUE.
- `branch_en` in 1: redirect request; sampled only in ISSUE when `stall`=0.
- `branch_target` in 32: redirect address; bits [1:0] ignored and forced to 0.
- `imem_req` out 1: fetch request; high only in FETCH.
- `imem_addr` out 32: equals PC at all times.
- `imem_ready` in 1: memory has `imem_rdata` valid this cycle; ignored outside FETCH.
- `imem_rdata` in 32: fetched word.
- `instr` out 32: last captured instruction word; drives the instruction register data input.
- `instr_load` out 1: one-cycle load pulse to the instruction register.
- `pc` out 32: current PC.
- `pc_plus4` out 32: PC + 4, modulo 2^32.
- `fetch_err` out 1: sticky timeout flag.

## Operation
- States: IDLE, FETCH, ISSUE, ERROR.
- IDLE
  - Outputs: `imem_req`=0, `instr_load`=0.
  - Next state: FETCH, unconditionally.
- FETCH
  - Outputs: `imem_req`=1, `imem_addr`=PC.
  - If `imem_ready`=1: register `imem_rdata` into `instr`, clear `wait_cnt`, go to ISSUE.
  - Otherwise, if `wait_cnt`==`WAIT_MAX`-1: set `fetch_err`, go to ERROR.
  - Otherwise: increment `wait_cnt` and stay in FETCH.
- ISSUE
  - `instr_load` = !`stall` (Moore on state, gated combinationally by `stall`).
  - If `stall`=0: PC <= `branch_en` ? {`branch_target`[31:2], 2'b00} : PC+4. Go to FETCH.
  - If `stall`=1: PC and `instr` are held; stay in ISSUE.
- ERROR
  - Outputs: `imem_req`=0, `instr_load`=0, `fetch_err`=1.
  - Exits only via `reset`.
- PC arithmetic: 32-bit unsigned addition, wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- Reset values (registered on the reset edge):
  - state = IDLE, PC = `PC_RESET`, `instr` = 0, `wait_cnt` = 0, `fetch_err` = 0.
  - Hence `imem_req`=0, `instr_load`=0, `imem_addr`=`PC_RESET`, `pc_plus4`=`PC_RESET`+4.
- Reset has priority over every other input, in every state.
- Reset during FETCH abandons the request. An `imem_ready` arriving after the reset edge is ignored because the stage is in IDLE.
- `branch_en` and `branch_target` are don't-care outside ISSUE, and in ISSUE while `stall`=1.

## Timing
- Reset released at edge k (reset=0 sampled): IDLE→FETCH at edge k; `imem_req`=1 during cycle k..k+1.
- Zero-wait memory (`imem_ready`=1 in the first FETCH cycle): 2 cycles per instruction (FETCH, ISSUE).
- Each wait cycle adds 1 cycle.
- `instr` is stable from the edge that leaves FETCH until the next capture. It is therefore valid throughout the `instr_load` pulse and on the edge that ends it.
- Exactly one `instr_load` pulse per successful fetch, regardless of stall length.
- Redirect takes effect on the next FETCH address; no fetch is wasted.
- Timeout: with `imem_ready` held low, `fetch_err` rises at the edge ending the `WAIT_MAX`-th FETCH cycle, and `imem_req` falls in the same cycle.

## Structure
- Shared package `fetch_pkg`:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2, ERROR=2'd3),
  - `PC_STEP`=4,
  - `WORD_W`=32.
- One sub-module, `pc_unit`: a 32-bit load-enabled PC register with synchronous reset to `PC_RESET` and a next-PC mux (PC+4 / aligned target). It produces `pc` and `pc_plus4`.
- FSM, `wait_cnt` and `instr` capture live in `instr_fetch`.

## Test plan
- Reset, zero-wait memory returning 32'h2008_0005 at address 0 → `imem_req` at addr 0x0 in the first cycle; `instr_load` pulse with `instr`=32'h2008_0005 one cycle later; next `imem_addr`=0x4.
- `imem_ready` delayed 3 cycles at addr 0x8 → `imem_req` high and `imem_addr`=0x8 stable for 4 cycles; single `instr_load` pulse; `wait_cnt` cleared; `fetch_err`=0.
- ISSUE with `branch_en`=1, `branch_target`=32'h0000_0103 → next `imem_addr`=32'h0000_0100, `pc_plus4`=32'h0000_0104.
- `stall`=1 for 4 ISSUE cycles at PC=0xC → `instr_load`=0 and PC=0xC throughout; one pulse in the cycle `stall` drops; next addr 0x10.
- `imem_ready` held low, `WAIT_MAX`=15 → `fetch_err`=1 after the 15th FETCH cycle, `imem_req`=0, state held through 20 further cycles; `reset` clears `fetch_err`.
- `reset` asserted in the 2nd wait cycle at PC=0x20, `imem_ready` arrives the following cycle → `imem_req`=0 the cycle after the reset edge, PC=`PC_RESET`, no `instr_load`, `instr`=0.
